// File: rtl/pll_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and constants for the PLL reset/lock sequencer.
//               Provides the sequencer state enum, the default timing values
//               for a 12 MHz reference, and the helper that sizes the shared
//               phase timer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // Default timing for a 12 MHz reference clock
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;     // PLL reset pulse width
    localparam int unsigned DEF_LOCK_TIMEOUT   = 12000;  // 1 ms lock window
    localparam int unsigned DEF_STABLE_CYCLES  = 1200;   // 100 us qualification
    localparam int unsigned DEF_MAX_RETRIES    = 4;
    localparam int unsigned DEF_CNT_W          = 8;

    // Width of the shared phase timer. STABILIZE terminates when the timer
    // equals STABLE_CYCLES itself (not STABLE_CYCLES-1), so the timer must be
    // able to hold the largest cycle constant, hence the +1.
    function automatic int unsigned timer_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_seq_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer for asynchronous level inputs.
//               Each bit is synchronized independently; multi-bit use is only
//               safe for unrelated or gray-coded signals.
// Ports       : clk_i  - destination clock
//               rst_i  - synchronous active-high reset, clears both stages
//               d_i    - asynchronous input
//               q_o    - synchronized output (2 clk_i cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL reset and lock sequencer on the 12 MHz board clock.
//               Pulses the PLL reset, waits for LOCK (retrying on timeout),
//               qualifies lock for a stable interval, then releases the system
//               reset. Loss of lock in RUN restarts the whole sequence.
// Ports       : clk_i         - 12 MHz board clock (also PLL reference)
//               rst_i         - synchronous active-high reset
//               pll_lock_i    - PLL LOCK, asynchronous to clk_i
//               pll_rst_req_i - single-cycle request to force a re-lock
//               pll_rst_o     - PLL RESET pin
//               sys_rst_o     - system reset, high until PLL clock qualified
//               pll_ready_o   - high in RUN (inverse of sys_rst_o)
//               fail_o        - sticky, retry count reached MAX_RETRIES
//               retry_cnt_o   - saturating count of lock timeouts
//               lost_cnt_o    - saturating count of lock losses in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pll_lock_i,
    input  logic             pll_rst_req_i,
    output logic             pll_rst_o,
    output logic             sys_rst_o,
    output logic             pll_ready_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] retry_cnt_o,
    output logic [CNT_W-1:0] lost_cnt_o
);

    localparam int unsigned TMR_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Terminal timer values for each timed phase
    localparam logic [TMR_W-1:0] c_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    // STABILIZE spends STABLE_CYCLES+1 cycles so that a lock rise seen in
    // WAIT_LOCK releases sys_rst STABLE_CYCLES+4 cycles later (2 sync stages,
    // 1 entry cycle, STABLE_CYCLES+1 qualification cycles).
    localparam logic [TMR_W-1:0] c_STB_LAST = TMR_W'(STABLE_CYCLES);
    localparam logic [TMR_W-1:0] c_TMR_ONE  = TMR_W'(1);

    localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX_RETRIES = CNT_W'(MAX_RETRIES);

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    pll_state_e       state_q,   state_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [CNT_W-1:0] retry_q,   retry_d;
    logic [CNT_W-1:0] lost_q,    lost_d;
    logic             fail_q,    fail_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + c_TMR_ONE;
        retry_d = retry_q;
        lost_d  = lost_q;

        if (pll_rst_req_i) begin
            // Forced re-lock outranks any lock-driven move, so a loss seen
            // in the same cycle is not counted.
            state_d = PLL_RESET;
            timer_d = '0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (timer_q == c_RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end
                end

                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == c_TMO_LAST) begin
                        state_d = PLL_RESET;
                        timer_d = '0;
                        if (retry_q != c_CNT_MAX) begin
                            retry_d = retry_q + c_CNT_ONE;
                        end
                    end
                end

                STABILIZE: begin
                    // Any low sample restarts the wait without counting a retry
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == c_STB_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RESET;
                        timer_d = '0;
                        if (lost_q != c_CNT_MAX) begin
                            lost_d = lost_q + c_CNT_ONE;
                        end
                    end else begin
                        // Timer is idle in RUN; keep it parked at zero
                        timer_d = '0;
                    end
                end

                default: begin
                    state_d = PLL_RESET;
                    timer_d = '0;
                end
            endcase
        end

        // Sticky; evaluated on the next count so it rises with retry_cnt
        fail_d    = fail_q | (retry_d >= c_MAX_RETRIES);

        // Outputs decoded from the next state so they switch with the state
        pll_rst_d = (state_d == PLL_RESET);
        sys_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PLL_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            fail_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            fail_q    <= fail_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_rst_o   = sys_rst_q;
    assign pll_ready_o = ~sys_rst_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;
    assign lost_cnt_o  = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Scoreboard bench for pll_reset_seq. Stimulus pushes the
//               predicted output change (cycle + values) for each directed
//               vector; a monitor pops and compares on every output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       pll_rst_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;

    pll_reset_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2),
        .CNT_W          (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_lock_i    (pll_lock),
        .pll_rst_req_i (pll_rst_req),
        .pll_rst_o     (pll_rst),
        .sys_rst_o     (sys_rst),
        .pll_ready_o   (pll_ready),
        .fail_o        (fail),
        .retry_cnt_o   (retry_cnt),
        .lost_cnt_o    (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output change: {pll_rst, sys_rst, pll_ready, fail, retry, lost}
    typedef struct {
        int          cyc;
        int          scen;
        logic [19:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    function automatic string scen_name(input int s);
        case (s)
            0:       return "clean_lock";
            1:       return "loss_in_run";
            2:       return "force_priority";
            3:       return "unstable_lock";
            4:       return "mid_op_reset";
            5:       return "timeout_fail_sat";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int scen, input int dlt, input logic pr, input logic sr,
                        input logic fl, input int rc, input int lc);
        exp_t e;
        e.cyc  = cyc + dlt;
        e.scen = scen;
        e.v    = {pr, sr, ~sr, fl, 8'(rc), 8'(lc)};
        q.push_back(e);
    endtask

    task automatic goto(input int t);
        if (cyc > t) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: now cyc=%0d, target cyc=%0d already passed", cyc, t);
        end
        while (cyc < t) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: any change on the outputs is one vector
    // ------------------------------------------------------------------
    logic [19:0] prev = '0;
    logic [19:0] cur;
    exp_t        em;

    always @(negedge clk) begin
        if (!done) begin
            cur = {pll_rst, sys_rst, pll_ready, fail, retry_cnt, lost_cnt};
            if (cur !== prev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: cyc=%0d got pr=%b sr=%b rdy=%b fail=%b retry=%0d lost=%0d, want no change",
                             cyc, cur[19], cur[18], cur[17], cur[16], cur[15:8], cur[7:0]);
                end else begin
                    em = q.pop_front();
                    if (em.cyc != cyc || cur !== em.v) begin
                        n_err++;
                        $display("FAIL %s: got cyc=%0d pr=%b sr=%b rdy=%b fail=%b retry=%0d lost=%0d, want cyc=%0d pr=%b sr=%b rdy=%b fail=%b retry=%0d lost=%0d",
                                 scen_name(em.scen), cyc, cur[19], cur[18], cur[17], cur[16], cur[15:8], cur[7:0],
                                 em.cyc, em.v[19], em.v[18], em.v[17], em.v[16], em.v[15:8], em.v[7:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (drives at negedge, deltas are in clk cycles from the drive)
    // ------------------------------------------------------------------
    initial begin
        int d;
        exp_t e;

        rst         = 1'b1;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b0;

        // Reset state after the first edge
        push(0, 1, 1, 1, 0, 0, 0);

        // Clean lock: pll_rst 4 cycles, lock 5 after fall, release 12 later
        goto(3);
        rst = 1'b0;
        d = cyc;
        push(0, 4, 0, 1, 0, 0, 0);
        goto(d + 9);
        pll_lock = 1'b1;
        push(0, 12, 0, 0, 0, 0, 0);
        goto(d + 24);

        // Loss in RUN: 3-cycle reaction, lost 0->1, full re-sequence
        d = cyc;
        pll_lock = 1'b0;
        push(1, 3, 1, 1, 0, 0, 1);
        push(1, 7, 0, 1, 0, 0, 1);
        goto(d + 9);
        pll_lock = 1'b1;
        push(1, 12, 0, 0, 0, 0, 1);
        goto(d + 24);

        // Request in the cycle lock_s falls; then re-request on 3rd reset cycle
        d = cyc;
        pll_lock = 1'b0;
        push(2, 3, 1, 1, 0, 0, 1);
        push(2, 10, 0, 1, 0, 0, 1);
        goto(d + 2);  pll_rst_req = 1'b1;
        goto(d + 3);  pll_rst_req = 1'b0;
        goto(d + 5);  pll_rst_req = 1'b1;
        goto(d + 6);  pll_rst_req = 1'b0;
        goto(d + 12);
        pll_lock = 1'b1;
        push(2, 12, 0, 0, 0, 0, 1);
        goto(d + 27);

        // Unstable lock: one-cycle drop after 5 stable samples
        d = cyc;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b1;
        push(3, 1, 1, 1, 0, 0, 1);
        push(3, 5, 0, 1, 0, 0, 1);
        push(3, 26, 0, 0, 0, 0, 1);
        goto(d + 1);  pll_rst_req = 1'b0;
        goto(d + 7);  pll_lock = 1'b1;
        goto(d + 13); pll_lock = 1'b0;
        goto(d + 14); pll_lock = 1'b1;
        goto(d + 29);

        // Mid-operation reset in STABILIZE with retry_cnt=1, fail=0
        d = cyc;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b1;
        push(4, 1, 1, 1, 0, 0, 1);
        push(4, 5, 0, 1, 0, 0, 1);
        push(4, 25, 1, 1, 0, 1, 1);
        push(4, 29, 0, 1, 0, 1, 1);
        push(4, 35, 1, 1, 0, 0, 0);
        push(4, 39, 0, 1, 0, 0, 0);
        push(4, 49, 0, 0, 0, 0, 0);
        goto(d + 1);  pll_rst_req = 1'b0;
        goto(d + 29); pll_lock = 1'b1;
        goto(d + 34); rst = 1'b1;
        goto(d + 35); rst = 1'b0;
        goto(d + 52);

        // Timeouts: 24-cycle retry period, fail at retry 2, saturation at 255
        d = cyc;
        pll_lock    = 1'b0;
        pll_rst_req = 1'b1;
        push(5, 1, 1, 1, 0, 0, 0);
        push(5, 5, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 257; k++) begin
            push(5, 1 + 24 * k, 1, 1, (k >= 2), (k > 255) ? 255 : k, 0);
            push(5, 5 + 24 * k, 0, 1, (k >= 2), (k > 255) ? 255 : k, 0);
        end
        goto(d + 1);  pll_rst_req = 1'b0;
        goto(d + 5 + 24 * 257 + 5);

        done = 1'b1;
        while (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: got no change by cyc=%0d, want change at cyc=%0d (pr=%b sr=%b fail=%b retry=%0d lost=%0d)",
                     scen_name(e.scen), cyc, e.cyc, e.v[19], e.v[18], e.v[16], e.v[15:8], e.v[7:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, cyc=%0d vectors=%0d", cyc, n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset and lock sequencer that sits directly downstream of the on-chip rPLL wrapper.
- Runs on the stable 12 MHz board clock, which is also the PLL input clock.
- Resets the PLL and watches its LOCK output, retrying when lock fails.
- Holds the system reset asserted until lock has been stable for a qualified interval. Drops back to reset on loss of lock.
- Consumers in the PLL clock domain re-synchronize sys_rst locally; that synchronizer is outside this block.

Parameters:
- PLL_RST_CYCLES, 16: clk cycles pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 12000: clk cycles allowed in WAIT_LOCK before retrying (1 ms at 12 MHz).
- STABLE_CYCLES, 1200: consecutive high lock samples required before release (100 us).
- MAX_RETRIES, 4: failed lock attempts after which fail is asserted (>=1).
- CNT_W, 8: width of the retry and loss counters.

Ports:
- clk, in, 1: 12 MHz board clock.
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL LOCK; asynchronous to clk.
- pll_rst_req, in, 1: single-cycle request to force a PLL re-lock.
- pll_rst, out, 1: drives the PLL RESET pin.
- sys_rst, out, 1: system reset; high until the PLL clock is qualified.
- pll_ready, out, 1: high in RUN, equal to ~sys_rst.
- fail, out, 1: sticky; retry_cnt has reached MAX_RETRIES.
- retry_cnt, out, CNT_W: count of lock timeouts; saturating.
- lost_cnt, out, CNT_W: count of lock losses while in RUN; saturating.

Behaviour:
- Synchronization: pll_lock passes through a 2-FF synchronizer to give lock_s. Both flops clear to 0 on rst.
- Outputs: all registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: state=PLL_RESET with timer=0; pll_rst=1, sys_rst=1, pll_ready=0, fail=0, retry_cnt=0, lost_cnt=0.
- Timer: single shared timer, width $clog2 of the max of the three cycle parameters. It clears on every state transition.
- PLL_RESET: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0.
- WAIT_LOCK, lock_s=1: go to STABILIZE.
- WAIT_LOCK, lock_s=0: timer increments. At timer==LOCK_TIMEOUT-1, go to PLL_RESET and increment retry_cnt (saturating).
- WAIT_LOCK, fail: fail sets on the edge where retry_cnt becomes >= MAX_RETRIES. Retries continue indefinitely after fail.
- STABILIZE, lock_s=0: return to WAIT_LOCK. Timer clears; retry_cnt is not incremented.
- STABILIZE, lock_s=1: after STABLE_CYCLES consecutive lock_s=1 samples, go to RUN.
- STABILIZE latency: a pll_lock rise during WAIT_LOCK, held steady, gives a sys_rst fall exactly STABLE_CYCLES+4 clk cycles later.
- RUN: sys_rst=0, pll_ready=1. On lock_s=0, go to PLL_RESET and increment lost_cnt (saturating).
- RUN latency: pll_lock fall to sys_rst/pll_rst rise is 3 cycles.
- RUN, retry_cnt: left unchanged on entry; only rst clears it.
- pll_rst_req: in any state, go to PLL_RESET with timer=0 on the next edge. In PLL_RESET this restarts the full PLL_RST_CYCLES hold.
- pll_rst_req vs lock loss: a request has priority over lock loss in the same cycle, and lost_cnt is not incremented.
- Priority order: rst, then pll_rst_req, then lock-driven transitions, then timer expiry.
- Mid-operation rst: returns to reset values on the next edge from any state, and clears counters and fail.
- Glitch: a lock_s low pulse of one cycle in RUN counts as a loss. No filtering beyond the synchronizer.
- Saturation: both counters stop at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package pll_seq_pkg: state enum {PLL_RESET, WAIT_LOCK, STABILIZE, RUN}, default timing constants, and a function giving the timer width.
- One natural sub-module, sync_2ff, a generic bit synchronizer. It is reused elsewhere for other async inputs.

Test Plan:
- Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: after rst, pll_rst is high for 4 cycles. Raise pll_lock 5 cycles after pll_rst falls → sys_rst falls exactly 12 cycles later; pll_ready=1; retry_cnt=0.
- Timeout and fail: hold pll_lock=0 → pll_rst re-pulses every 24 cycles (4+20) and retry_cnt steps 1, 2. fail rises with retry_cnt=2 and stays high; retry_cnt saturates at 255 on a long run.
- Unstable lock: in STABILIZE, drop pll_lock for 1 cycle after 5 high → back to WAIT_LOCK, sys_rst stays high, retry_cnt unchanged. Hold high → release STABLE_CYCLES+4 cycles after the re-rise.
- Loss in RUN: drop pll_lock → sys_rst and pll_rst high 3 cycles later; lost_cnt 0→1; full re-sequence then completes.
- Force and priority: pll_rst_req in RUN in the same cycle lock_s falls → PLL_RESET, lost_cnt unchanged. pll_rst_req on the 3rd cycle of PLL_RESET → pll_rst stays high 4 more cycles.
- Mid-operation reset: assert rst in STABILIZE with retry_cnt=1 and fail=0 → next edge all outputs at reset values; sequence restarts.
